dm_cache_arrays: RTL and testbench

- Storage arrays of the direct-mapped L1 data cache: one tag array (valid, dirty, tag per line) and one data array (128-bit line per entry).
- Implemented as two submodules, dm_cache_tag and dm_cache_data, which share the index/we request format. dm_cache_arrays instantiates both and exposes their ports unchanged.
- Driven by the cache FSM: it indexes with addr[5:4], compares tags with addr[31:6] and selects words with addr[3:2].
- Both arrays use asynchronous (combinational) read and synchronous write, so the FSM can read-modify-write a line within one cycle.

---
 rtl/dm_cache_arrays.sv | 146 ++++++++++++++
 tb/tb_dm_cache_arrays.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_arrays.sv
// Tag and data storage arrays for the direct-mapped L1 data cache.
// Both arrays read combinationally and write on the rising clock edge.

module dm_cache_tag #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned TAG_W     = 26,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] tag_req_index,
  input  logic             tag_req_we,
  input  logic             tag_write_valid,
  input  logic             tag_write_dirty,
  input  logic [TAG_W-1:0] tag_write_tag,
  output logic             tag_read_valid,
  output logic             tag_read_dirty,
  output logic [TAG_W-1:0] tag_read_tag
);

  localparam int unsigned ENTRY_W = TAG_W + 2;

  // Entry layout: {valid, dirty, tag}
  logic [ENTRY_W-1:0] tag_mem_q [NUM_LINES];
  logic [ENTRY_W-1:0] tag_mem_d [NUM_LINES];

  always_comb begin
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      tag_mem_d[i] = tag_mem_q[i];
    end
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_mem_d[i] = '0;
      end
    end else if (tag_req_we) begin
      tag_mem_d[tag_req_index] = {tag_write_valid, tag_write_dirty, tag_write_tag};
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      tag_mem_q[i] <= tag_mem_d[i];
    end
  end

  // Read path sees the pre-edge contents, so a same-cycle write is not bypassed.
  always_comb begin
    {tag_read_valid, tag_read_dirty, tag_read_tag} = tag_mem_q[tag_req_index];
  end

endmodule

module dm_cache_data #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  data_req_index,
  input  logic              data_req_we,
  input  logic [LINE_W-1:0] data_write,
  output logic [LINE_W-1:0] data_read
);

  logic [LINE_W-1:0] data_mem_q [NUM_LINES];
  logic [LINE_W-1:0] data_mem_d [NUM_LINES];

  always_comb begin
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      data_mem_d[i] = data_mem_q[i];
    end
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        data_mem_d[i] = '0;
      end
    end else if (data_req_we) begin
      data_mem_d[data_req_index] = data_write;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      data_mem_q[i] <= data_mem_d[i];
    end
  end

  always_comb begin
    data_read = data_mem_q[data_req_index];
  end

endmodule

module dm_cache_arrays #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned TAG_W     = 26,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  tag_req_index,
  input  logic              tag_req_we,
  input  logic              tag_write_valid,
  input  logic              tag_write_dirty,
  input  logic [TAG_W-1:0]  tag_write_tag,
  output logic              tag_read_valid,
  output logic              tag_read_dirty,
  output logic [TAG_W-1:0]  tag_read_tag,
  input  logic [IDX_W-1:0]  data_req_index,
  input  logic              data_req_we,
  input  logic [LINE_W-1:0] data_write,
  output logic [LINE_W-1:0] data_read
);

  dm_cache_tag #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W)
  ) u_tag (
    .clock           (clock),
    .reset           (reset),
    .tag_req_index   (tag_req_index),
    .tag_req_we      (tag_req_we),
    .tag_write_valid (tag_write_valid),
    .tag_write_dirty (tag_write_dirty),
    .tag_write_tag   (tag_write_tag),
    .tag_read_valid  (tag_read_valid),
    .tag_read_dirty  (tag_read_dirty),
    .tag_read_tag    (tag_read_tag)
  );

  dm_cache_data #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W),
    .IDX_W     (IDX_W)
  ) u_data (
    .clock          (clock),
    .reset          (reset),
    .data_req_index (data_req_index),
    .data_req_we    (data_req_we),
    .data_write     (data_write),
    .data_read      (data_read)
  );

endmodule

// File: tb/tb_dm_cache_arrays.sv
// Directed and random checks of dm_cache_arrays against an array-based reference model.

module tb_dm_cache_arrays;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   tag_req_index;
  logic         tag_req_we;
  logic         tag_write_valid;
  logic         tag_write_dirty;
  logic [25:0]  tag_write_tag;
  logic         tag_read_valid;
  logic         tag_read_dirty;
  logic [25:0]  tag_read_tag;
  logic [1:0]   data_req_index;
  logic         data_req_we;
  logic [127:0] data_write;
  logic [127:0] data_read;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  // Reference contents: tag entry as {valid, dirty, tag}, data as full line.
  logic [27:0]  tag_m  [4];
  logic [127:0] data_m [4];

  always #5 clock = ~clock;

  dm_cache_arrays #(
    .NUM_LINES (4),
    .TAG_W     (26),
    .LINE_W    (128)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .tag_req_index   (tag_req_index),
    .tag_req_we      (tag_req_we),
    .tag_write_valid (tag_write_valid),
    .tag_write_dirty (tag_write_dirty),
    .tag_write_tag   (tag_write_tag),
    .tag_read_valid  (tag_read_valid),
    .tag_read_dirty  (tag_read_dirty),
    .tag_read_tag    (tag_read_tag),
    .data_req_index  (data_req_index),
    .data_req_we     (data_req_we),
    .data_write      (data_write),
    .data_read       (data_read)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [27:0] tag_obs();
    return {tag_read_valid, tag_read_dirty, tag_read_tag};
  endfunction

  // One rising edge; the model applies the same edge using the inputs held across it.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        tag_m[i]  = '0;
        data_m[i] = '0;
      end
    end else begin
      if (tag_req_we)  tag_m[tag_req_index]   = {tag_write_valid, tag_write_dirty, tag_write_tag};
      if (data_req_we) data_m[data_req_index] = data_write;
    end
    #1;
  endtask

  task automatic idle();
    tag_req_we  = 1'b0;
    data_req_we = 1'b0;
  endtask

  initial begin
    logic [127:0] line;
    logic [127:0] old_line;
    reset = 1'b1; tag_req_index = '0; tag_req_we = 1'b0;
    tag_write_valid = 1'b0; tag_write_dirty = 1'b0; tag_write_tag = '0;
    data_req_index = '0; data_req_we = 1'b0; data_write = '0;
    for (int i = 0; i < 4; i++) begin
      tag_m[i] = 'x; data_m[i] = 'x;
    end

    // Reset and zero sweep
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tag_req_index = 2'(i); data_req_index = 2'(i); #1;
      check($sformatf("reset_tag[%0d]", i), 128'(tag_obs()), 128'(28'h0));
      check($sformatf("reset_data[%0d]", i), data_read, 128'h0);
    end

    // Tag write at index 2
    tag_req_index = 2'd2; tag_req_we = 1'b1;
    tag_write_valid = 1'b1; tag_write_dirty = 1'b1; tag_write_tag = 26'h3ABCDE;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      tag_req_index = 2'(i); #1;
      check($sformatf("tagwr_idx%0d", i), 128'(tag_obs()),
            (i == 2) ? 128'({1'b1, 1'b1, 26'h3ABCDE}) : 128'(28'h0));
    end

    // Data write at index 1
    data_req_index = 2'd1; data_req_we = 1'b1;
    data_write = 128'h44444444_33333333_22222222_11111111;
    tick(); idle(); #1;
    check("datawr_line", data_read, 128'h44444444_33333333_22222222_11111111);
    line = data_read;
    check("datawr_word1", 128'(line[63:32]), 128'(32'h22222222));

    // Same-cycle read-modify-write of word 3
    data_req_index = 2'd1; #1;
    old_line = data_read;
    data_write = {32'hDEADBEEF, old_line[95:0]};
    data_req_we = 1'b1; #1;
    check("rmw_old_same_cycle", data_read, 128'h44444444_33333333_22222222_11111111);
    tick(); idle(); #1;
    check("rmw_new", data_read, 128'hDEADBEEF_33333333_22222222_11111111);

    // Reset takes priority over a write
    tag_req_index = 2'd0; tag_req_we = 1'b1;
    tag_write_valid = 1'b1; tag_write_dirty = 1'b0; tag_write_tag = 26'h1;
    reset = 1'b1;
    tick(); reset = 1'b0; idle(); #1;
    check("rst_prio_tag0", 128'(tag_obs()), 128'(28'h0));
    tag_req_index = 2'd2; data_req_index = 2'd1; #1;
    check("rst_clears_tag2", 128'(tag_obs()), 128'(28'h0));
    check("rst_clears_data1", data_read, 128'h0);

    // Independent arrays in the same cycle
    tag_req_index = 2'd3; tag_req_we = 1'b1;
    tag_write_valid = 1'b1; tag_write_dirty = 1'b0; tag_write_tag = 26'h2AAAAAA;
    data_req_index = 2'd0; data_req_we = 1'b1;
    data_write = 128'hCAFEF00D_01234567_89ABCDEF_FEDCBA98;
    tick(); idle(); #1;
    check("indep_tag3", 128'(tag_obs()), 128'({1'b1, 1'b0, 26'h2AAAAAA}));
    check("indep_data0", data_read, 128'hCAFEF00D_01234567_89ABCDEF_FEDCBA98);
    tag_req_index = 2'd0; data_req_index = 2'd3; #1;
    check("indep_tag0_untouched", 128'(tag_obs()), 128'(28'h0));
    check("indep_data3_untouched", data_read, 128'h0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      reset           = ($urandom_range(31) == 0);
      tag_req_index   = 2'($urandom_range(3));
      data_req_index  = 2'($urandom_range(3));
      tag_req_we      = 1'($urandom_range(1));
      data_req_we     = 1'($urandom_range(1));
      tag_write_valid = 1'($urandom_range(1));
      tag_write_dirty = 1'($urandom_range(1));
      tag_write_tag   = 26'($urandom);
      data_write      = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("rand%0d_tag", n), 128'(tag_obs()), 128'(tag_m[tag_req_index]));
      check($sformatf("rand%0d_data", n), data_read, data_m[data_req_index]);
      tick();
    end
    reset = 1'b0; idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
